// File: rtl/sa_sched_pkg.sv
// rtl/sa_sched_pkg.sv - shared types and helpers for the systolic-array job scheduler
package sa_sched_pkg;

  localparam int MAX_DIM_DEF = 128;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_CLEAR = 5'b00010,
    ST_START = 5'b00100,
    ST_WAIT  = 5'b01000,
    ST_DONE  = 5'b10000
  } sched_state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sa_rr_arbiter.sv
// rtl/sa_rr_arbiter.sv - combinational rotating-priority pick, search starts after last_id
module sa_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  output logic             any,
  output logic [ID_W-1:0]  win_id
);

  always_comb begin
    any    = 1'b0;
    win_id = '0;
    // Walk priority slots last_id+1 .. last_id+N_REQ; first requester found wins.
    for (int i = 1; i <= N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!any && req[j] && (j == ((int'(last_id) + i) % N_REQ))) begin
          any    = 1'b1;
          win_id = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/sa_job_scheduler.sv
// rtl/sa_job_scheduler.sv - round-robin job sequencer for the shared systolic array
module sa_job_scheduler
  import sa_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 3,
  parameter int TMO_CYC = 1023,
  parameter int MAX_DIM = MAX_DIM_DEF
) (
  input  logic               I_CLK,
  input  logic               I_ASYN_RSTN,
  input  logic [N_REQ-1:0]   I_REQ,
  input  logic [N_REQ*8-1:0] I_REQ_M_DIM,
  input  logic [N_REQ-1:0]   I_ACK,
  input  logic               I_SA_OUT_VLD,
  output logic               O_SA_SYNC_RSTN,
  output logic               O_SA_START,
  output logic [7:0]         O_SA_M_DIM,
  output logic [N_REQ-1:0]   O_GNT,
  output logic [ID_W-1:0]    O_GNT_ID,
  output logic [N_REQ-1:0]   O_DONE,
  output logic               O_ERR,
  output logic               O_BUSY
);

  localparam int CNT_W = clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);

  sched_state_t     state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d, last_id_q, last_id_d;
  logic [7:0]       m_dim_q, m_dim_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_rstn_q, sync_rstn_d, start_q, start_d;
  logic             err_q, err_d, busy_q, busy_d;

  logic             any;
  logic [ID_W-1:0]  win_id;
  logic [N_REQ-1:0] win_oh;
  logic [7:0]       win_dim;
  logic             dim_ok;

  sa_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req     (I_REQ),
    .last_id (last_id_q),
    .any     (any),
    .win_id  (win_id)
  );

  always_comb begin
    win_oh  = '0;
    win_dim = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (int'(win_id) == j) begin
        win_oh[j] = 1'b1;
        win_dim   = I_REQ_M_DIM[j*8 +: 8];
      end
    end
    dim_ok = (win_dim != 8'd0) && ({24'd0, win_dim} <= 32'(MAX_DIM));
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    last_id_d   = last_id_q;
    m_dim_d     = m_dim_q;
    done_d      = done_q;
    cnt_d       = cnt_q;
    sync_rstn_d = 1'b1;
    start_d     = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          gnt_d    = win_oh;
          gnt_id_d = win_id;
          m_dim_d  = win_dim;
          if (dim_ok) begin
            state_d     = ST_CLEAR;
            sync_rstn_d = 1'b0;
          end else begin
            // Illegal dimension: report and hand back without touching the array.
            state_d = ST_DONE;
            err_d   = 1'b1;
            done_d  = win_oh;
          end
        end
      end
      ST_CLEAR: begin
        state_d = ST_START;
        start_d = 1'b1;
      end
      ST_START: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (I_SA_OUT_VLD) begin
          state_d = ST_DONE;
          done_d  = gnt_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_DONE;
          done_d      = gnt_q;
          err_d       = 1'b1;
          sync_rstn_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if ((I_ACK & gnt_q) != '0) begin
          state_d   = ST_IDLE;
          last_id_d = gnt_id_q;
          gnt_d     = '0;
          done_d    = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        done_d  = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      last_id_q   <= ID_W'(N_REQ - 1);
      m_dim_q     <= '0;
      done_q      <= '0;
      cnt_q       <= '0;
      sync_rstn_q <= 1'b1;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      last_id_q   <= last_id_d;
      m_dim_q     <= m_dim_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      sync_rstn_q <= sync_rstn_d;
      start_q     <= start_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign O_SA_SYNC_RSTN = sync_rstn_q;
  assign O_SA_START     = start_q;
  assign O_SA_M_DIM     = m_dim_q;
  assign O_GNT          = gnt_q;
  assign O_GNT_ID       = gnt_id_q;
  assign O_DONE         = done_q;
  assign O_ERR          = err_q;
  assign O_BUSY         = busy_q;

endmodule

// File: tb/tb_sa_job_scheduler.sv
// tb/tb_sa_job_scheduler.sv - randomized job traffic against a transaction-level scheduler model
module tb_sa_job_scheduler;

  localparam int N_REQ = 4;
  localparam int ID_W  = 3;
  localparam int TMO   = 20;
  localparam int MAXD  = 128;

  logic               clk;
  logic               rstn;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*8-1:0] mdim;
  logic [N_REQ-1:0]   ack;
  logic               vld;
  logic               sa_sync_rstn;
  logic               sa_start;
  logic [7:0]         sa_m_dim;
  logic [N_REQ-1:0]   gnt;
  logic [ID_W-1:0]    gnt_id;
  logic [N_REQ-1:0]   done;
  logic               err;
  logic               busy;

  int total;
  int bad;
  int last;
  logic [3:0] pend;
  logic [7:0] dim [N_REQ];

  sa_job_scheduler #(
    .N_REQ   (N_REQ),
    .ID_W    (ID_W),
    .TMO_CYC (TMO),
    .MAX_DIM (MAXD)
  ) dut (
    .I_CLK          (clk),
    .I_ASYN_RSTN    (rstn),
    .I_REQ          (req),
    .I_REQ_M_DIM    (mdim),
    .I_ACK          (ack),
    .I_SA_OUT_VLD   (vld),
    .O_SA_SYNC_RSTN (sa_sync_rstn),
    .O_SA_START     (sa_start),
    .O_SA_M_DIM     (sa_m_dim),
    .O_GNT          (gnt),
    .O_GNT_ID       (gnt_id),
    .O_DONE         (done),
    .O_ERR          (err),
    .O_BUSY         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] p, input int l);
    for (int i = 1; i <= N_REQ; i++) begin
      if (p[(l + i) % N_REQ]) return (l + i) % N_REQ;
    end
    return 0;
  endfunction

  function automatic bit legal(input logic [7:0] d);
    return (d != 8'd0) && (int'(d) <= MAXD);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_rstn"},  sa_sync_rstn, 1);
    chk({tag, "_start"}, sa_start, 0);
    chk({tag, "_mdim"},  sa_m_dim, 0);
    chk({tag, "_gnt"},   gnt, 0);
    chk({tag, "_gntid"}, gnt_id, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_err"},   err, 0);
    chk({tag, "_busy"},  busy, 0);
  endtask

  // Entered at a negedge with the DUT idle; k = WAIT cycle in which valid is sampled (>=TMO: never).
  task automatic run_job(input int k, input bit stray, input bit wdraw);
    int w;
    int wait_cyc;
    bit tmo;
    logic [7:0] d;
    if (pend == 4'b0) pend = 4'b0001;
    for (int j = 0; j < N_REQ; j++) mdim[j*8 +: 8] = dim[j];
    req = pend;
    w = pick(pend, last);
    d = dim[w];
    @(negedge clk);
    chk("gnt", gnt, 32'(4'b1 << w));
    chk("gnt_id", gnt_id, w);
    chk("m_dim", sa_m_dim, d);
    chk("busy", busy, 1);
    if (!legal(d)) begin
      chk("err_dim", err, 1);
      chk("done_dim", done, 32'(4'b1 << w));
      chk("rstn_dim", sa_sync_rstn, 1);
      chk("start_dim", sa_start, 0);
    end else begin
      chk("clr_rstn", sa_sync_rstn, 0);
      chk("clr_err", err, 0);
      @(negedge clk);
      chk("start", sa_start, 1);
      chk("start_rstn", sa_sync_rstn, 1);
      tmo = (k >= TMO);
      wait_cyc = tmo ? TMO : k + 1;
      for (int c = 0; c < wait_cyc; c++) begin
        @(negedge clk);
        chk("wait_done", done, 0);
        chk("wait_start", sa_start, 0);
        chk("wait_err", err, 0);
        if (c == k) vld = 1'b1;
        if (wdraw && c == 0) req[w] = 1'b0;
      end
      @(negedge clk);
      chk("done", done, 32'(4'b1 << w));
      chk("done_err", err, 32'(tmo));
      chk("done_rstn", sa_sync_rstn, 32'(!tmo));
      chk("done_gnt", gnt, 32'(4'b1 << w));
      chk("done_mdim", sa_m_dim, d);
    end
    vld = 1'b0;
    if (stray) begin
      ack = 4'b1 << ((w + 1 + $urandom_range(0, 2)) % N_REQ);
      @(negedge clk);
      ack = '0;
      chk("stray_done", done, 32'(4'b1 << w));
      chk("stray_busy", busy, 1);
      chk("stray_err", err, 0);
    end
    ack = 4'b1 << w;
    pend[w] = 1'b0;
    req = pend;
    @(negedge clk);
    ack = '0;
    chk("idle_busy", busy, 0);
    chk("idle_gnt", gnt, 0);
    chk("idle_done", done, 0);
    last = w;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    req   = '0;
    ack   = '0;
    vld   = 1'b0;
    mdim  = '0;
    last  = N_REQ - 1;
    pend  = '0;
    for (int j = 0; j < N_REQ; j++) dim[j] = 8'(j * 8 + 8);
    #23;
    chk_reset("rst");
    @(negedge clk);
    rstn = 1'b1;

    pend = 4'b0100;
    run_job(10, 0, 0);
    dim[1] = 8'd16;
    pend = 4'b0010;
    run_job(39, 0, 0);
    for (int n = 0; n < 5; n++) begin
      pend = 4'b1111;
      run_job(3, 0, 0);
    end
    for (int j = 0; j < N_REQ; j++) dim[j] = 8'd0;
    pend = 4'b0001;
    run_job(5, 0, 0);
    for (int j = 0; j < N_REQ; j++) dim[j] = 8'd200;
    pend = 4'b0001;
    run_job(5, 0, 0);
    for (int j = 0; j < N_REQ; j++) dim[j] = 8'd128;
    pend = 4'b0100;
    run_job(25, 0, 0);
    pend = 4'b0100;
    run_job(TMO - 1, 0, 0);
    pend = 4'b1000;
    run_job(7, 1, 1);

    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if ($urandom_range(0, 7) == 0) dim[j] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(129, 255));
        else dim[j] = 8'($urandom_range(1, 128));
      end
      pend = pend | 4'($urandom_range(0, 15));
      run_job($urandom_range(0, 24), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    for (int j = 0; j < N_REQ; j++) mdim[j*8 +: 8] = 8'd32;
    req = 4'b0001;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset("arst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("re_gnt", gnt, 1);
    chk("re_gntid", gnt_id, 0);
    chk("re_rstn", sa_sync_rstn, 0);
    @(negedge clk);
    chk("re_start", sa_start, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
